// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: shared opcode constants, immediate format tag and the decoded
// result record passed from imm_decode to the imm_gen_pipe registers.
// Result fields are sized for the widest datapath (64 bits). Narrower
// configurations carry sign-extended values and use only the low XLEN bits.
package imm_pkg;

  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] imm;
    imm_fmt_e            fmt;
    logic [MAX_XLEN-1:0] target;
    logic                illegal;
  } imm_res_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle.
//   in_valid/in_ready/in_inst/in_pc          : instruction from fetch/decode
//   out_valid/out_ready/out_imm/out_fmt/
//   out_target/out_illegal                    : result towards execute
// slave  = the immediate generator, master = the surrounding pipeline.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
) ();
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_fmt_e        out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: purely combinational RV32I/RV64I immediate decoder.
//   i_inst : 32-bit instruction word
//   i_pc   : instruction PC (XLEN bits)
//   o_res  : sign-extended immediate, format tag, PC-relative target and
//            illegal flag, widened to the package's 64-bit record.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output imm_res_t        o_res
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_shamt5, w_shamt6;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  imm_fmt_e        w_fmt;
  logic            w_illegal;
  logic            w_use_pc;

  assign w_opcode   = i_inst[6:0];
  assign w_funct3   = i_inst[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  // A size cast of a signed operand sign-extends to XLEN.
  assign w_imm_i  = XLEN'($signed(i_inst[31:20]));
  assign w_imm_s  = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
  assign w_imm_b  = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25],
                                   i_inst[11:8], 1'b0}));
  assign w_imm_u  = XLEN'($signed({i_inst[31:12], 12'b0}));
  assign w_imm_j  = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20],
                                   i_inst[30:21], 1'b0}));
  assign w_shamt5 = XLEN'(i_inst[24:20]);
  assign w_shamt6 = XLEN'(i_inst[25:20]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    w_imm     = '0;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    w_use_pc  = 1'b0;
    case (w_opcode)
      OPC_LOAD, OPC_JALR, OPC_MISCMEM, OPC_SYSTEM: begin
        w_imm = w_imm_i;
        w_fmt = FMT_I;
      end
      OPC_OPIMM: begin
        if (w_is_shift) begin
          w_fmt     = FMT_SHAMT;
          w_imm     = IS_RV64 ? w_shamt6 : w_shamt5;
          // A 6-bit shift amount has no meaning on a 32-bit datapath.
          w_illegal = !IS_RV64 && i_inst[25];
        end else begin
          w_imm = w_imm_i;
          w_fmt = FMT_I;
        end
      end
      OPC_OPIMM32: begin
        if (!IS_RV64) begin
          w_illegal = 1'b1;
        end else if (w_is_shift) begin
          w_fmt = FMT_SHAMT;
          w_imm = w_shamt5;
        end else begin
          w_imm = w_imm_i;
          w_fmt = FMT_I;
        end
      end
      OPC_STORE: begin
        w_imm = w_imm_s;
        w_fmt = FMT_S;
      end
      OPC_BRANCH: begin
        w_imm    = w_imm_b;
        w_fmt    = FMT_B;
        w_use_pc = 1'b1;
      end
      OPC_LUI: begin
        w_imm = w_imm_u;
        w_fmt = FMT_U;
      end
      OPC_AUIPC: begin
        w_imm    = w_imm_u;
        w_fmt    = FMT_U;
        w_use_pc = 1'b1;
      end
      OPC_JAL: begin
        w_imm    = w_imm_j;
        w_fmt    = FMT_J;
        w_use_pc = 1'b1;
      end
      OPC_OP:   w_illegal = 1'b0;
      OPC_OP32: w_illegal = !IS_RV64;
      default:  w_illegal = 1'b1;
    endcase
  end

  // JALR is deliberately excluded: its target depends on rs1.
  assign w_target = w_use_pc ? (i_pc + w_imm) : '0;

  assign o_res.imm     = MAX_XLEN'($signed(w_imm));
  assign o_res.fmt     = w_fmt;
  assign o_res.target  = MAX_XLEN'($signed(w_target));
  assign o_res.illegal = w_illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with optional 2-entry skid.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   flush   : drop every held entry and any input offered this cycle
//   bus     : imm_gen_pipe_if.slave (instruction in, decoded result out)
// SKID_EN=1: output register + skid entry, in_ready = !skid_valid.
// SKID_EN=0: output register only, in_ready = !out_valid || out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  imm_res_t w_dec_res;
  imm_res_t r_out;
  imm_res_t r_skid;
  logic     r_out_valid;
  logic     r_skid_valid;
  logic     w_in_ready;
  logic     w_accept;
  logic     w_out_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_inst (bus.in_inst),
    .i_pc   (bus.in_pc),
    .o_res  (w_dec_res)
  );

  // Output register can take new data when empty or being drained now.
  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_in_ready = SKID_EN ? !r_skid_valid : w_out_free;
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: data registers are reset as well as the valid bits, because
      // the output fields must read zero after reset, not just be ignored.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      // Only the valid bits are killed; stale data is harmless.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge state, regardless of statement order.
      if (r_skid_valid) begin
        // in_ready was low, so no new input can arrive alongside this move.
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec_res;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept && SKID_EN) begin
      // Output stalled: park the new entry behind it.
      r_skid       <= w_dec_res;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_imm     = r_out.imm[XLEN-1:0];
  assign bus.out_fmt     = r_out.fmt;
  assign bus.out_target  = r_out.target[XLEN-1:0];
  assign bus.out_illegal = r_out.illegal;

  // Upper halves only hold sign copies on a 32-bit datapath.
  generate
    if (XLEN < MAX_XLEN) begin : g_hi_unused
      logic w_unused_hi;
      assign w_unused_hi = ^{r_out.imm[MAX_XLEN-1:XLEN],
                             r_out.target[MAX_XLEN-1:XLEN]};
    end
  endgenerate

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It accepts one instruction and its PC per valid/ready handshake and decodes all RV32I/RV64I immediate formats, including U-type and correctly sized shift amounts. It returns the sign-extended immediate, a format tag, a PC-relative target and an illegal flag one cycle later. A 2-entry skid buffer absorbs backpressure from execute, and a flush input kills in-flight entries on redirect.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
SKID_EN, 1, 1 gives a full skid buffer; 0 gives a single register with in_ready = !out_valid || out_ready.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  kill all held entries
in_valid  in  1  instruction valid
in_ready  out  1  block can accept an instruction
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  imm_fmt_e tag
out_target  out  XLEN  PC-relative target
out_illegal  out  1  unsupported opcode or shamt

Behaviour:
- Reset (asynchronous, reset_n=0):
  - out_valid=0, skid entry invalid.
  - out_imm, out_fmt (FMT_NONE), out_target and out_illegal all read 0.
  - in_ready=1, because it is combinational from !skid_valid.
- Decode by opcode in_inst[6:0]:
  - I format: LOAD 0000011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011 and OP-IMM 0010011. Immediate is sext(inst[31:20]).
  - SHAMT format: OP-IMM with funct3 001 or 101. Immediate is zero-extended inst[24:20] when XLEN=32, or inst[25:20] when XLEN=64.
    - When XLEN=32 and inst[25]=1, set illegal.
  - S format: 0100011. Immediate is sext({inst[31:25], inst[11:7]}).
  - B format: 1100011. Immediate is sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U format: LUI 0110111 and AUIPC 0010111. Immediate is sext({inst[31:12], 12'b0}).
  - J format: 1101111. Immediate is sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - OP-IMM-32 0011011: only when XLEN=64, decoded as I or SHAMT with a 5-bit shamt. When XLEN=32 it is illegal.
  - OP 0110011 and OP-32 (XLEN=64 only) give FMT_NONE with immediate 0 and are legal.
  - Any other opcode gives FMT_NONE, immediate 0, illegal=1.
- out_target:
  - in_pc + imm, truncated to XLEN, for B, J and AUIPC.
  - 0 for all other instructions, including JALR (rs1-dependent).
- Handshake:
  - Transfer on valid && ready.
  - Latency: input accepted at edge N is visible at out_* after edge N when the output register was empty or draining.
  - Output fields are held stable while out_valid && !out_ready.
- Skid buffer (SKID_EN=1):
  - When the output register is stalled and an input is accepted, the input goes to the skid entry; in_ready drops on the next cycle.
  - When the output drains, the skid entry moves to the output register and in_ready returns to 1.
  - Ordering is strictly FIFO. Sustained throughput is 1 per cycle with out_ready=1.
- Simultaneous events:
  - Output drain and input accept in the same cycle with skid empty: the output register loads the new entry directly.
  - Flush has priority over everything: both entries are invalidated next edge, and an input handshaked in the flush cycle is dropped.
  - out_valid=0 the cycle after flush; data registers need not clear.
- Reset mid-transfer: all entries are lost immediately, with no output glitch beyond an asynchronous drop of out_valid.

Decomposition:
- Shared package imm_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP32, OPC_SYSTEM, OPC_MISCMEM);
  - typedef enum logic[2:0] imm_fmt_e {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHAMT};
  - a packed struct imm_res_t {imm, fmt, target, illegal}.
- One combinational sub-module, imm_decode #(XLEN): maps inst and pc to imm_res_t.
- imm_gen_pipe holds only the output register, skid entry and handshake logic.

Test Plan:
1. Hold reset_n=0 with random inputs -> out_valid=0, out_imm=0, out_fmt=FMT_NONE, in_ready=1. Release reset -> same values until first accept.
2. XLEN=32: send addi 0xFFF00093 (pc 0x0) then srai 0x4070D093 back-to-back, out_ready=1:
   - addi -> out_imm=0xFFFFFFFF, FMT_I on the next cycle;
   - srai -> out_imm=0x00000007, FMT_SHAMT on the following cycle.
   - Send 0x0200D093 -> out_illegal=1.
3. beq 0xFE000EE3 with pc=0x100 -> out_imm=0xFFFFFFFC, FMT_B, out_target=0x000000FC. LUI 0x123450B7 -> out_imm=0x12345000, out_target=0.
4. out_ready=0 with in_valid=1 on three consecutive instructions A, B, C:
   - A and B are accepted; in_ready=0 from the third cycle; C is held.
   - Raise out_ready -> A, B, C emerge in order with no loss or duplication.
5. Stall with both entries full, assert flush for one cycle with in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the flush-cycle input never appears.
6. XLEN=64: slli 0x03F09093 -> out_imm=63, FMT_SHAMT, legal. Opcode 0x0000007F -> FMT_NONE, out_illegal=1. Drop reset_n mid-stall -> out_valid=0 immediately.
